dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dm_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory access controller between the MEM stage and a handshaked data memory.
// Defining DM_CTRL_TRACE_EN prints one trace line per store accepted by the memory.
module dm_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] PC,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } op_e;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    function automatic logic op_valid(input logic [3:0] o);
        return (o >= OP_LW) && (o <= OP_SB);
    endfunction

    function automatic logic op_store(input logic [3:0] o);
        return (o == OP_SW) || (o == OP_SH) || (o == OP_SB);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] o, input logic [1:0] a);
        case (o)
            OP_LW, OP_SW:         return a != 2'b00;
            OP_LH, OP_LHU, OP_SH: return a[0];
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [3:0] o, input logic [1:0] a);
        case (o)
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores are replicated across every lane; mem_be selects the live one.
    function automatic logic [31:0] store_data(input logic [3:0] o, input logic [31:0] w);
        case (o)
            OP_SH:   return {2{w[15:0]}};
            OP_SB:   return {4{w[7:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [3:0] o, input logic [1:0] a,
                                              input logic [31:0] rd);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = a[1] ? rd[31:16] : rd[15:0];
        byte_v = rd[{a, 3'b000} +: 8];
        case (o)
            OP_LW:   return rd;
            OP_LH:   return {{16{half_v[15]}}, half_v};
            OP_LHU:  return {16'd0, half_v};
            OP_LB:   return {{24{byte_v[7]}}, byte_v};
            OP_LBU:  return {24'd0, byte_v};
            default: return 32'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q, exc_d;
    logic        err_q, err_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rdata_d = 32'd0;
        exc_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid(op)) begin
                    if (op_misaligned(op, addr[1:0])) begin
                        state_d = ST_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        op_d    = op;
                        addr_d  = addr;
                        wdata_d = wdata;
                        pc_d    = PC;
                        cnt_d   = 10'd0;
                    end
                end
            end
            ST_REQ: begin
                // An acknowledge in the final allowed cycle still completes the access.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    rdata_d = load_data(op_q, addr_q[1:0], mem_rd);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            cnt_q   <= 10'd0;
            rdata_q <= 32'd0;
            exc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            err_q   <= err_d;
        end
    end

    // Request signals decode from state_q, so an asynchronous reset drops them at once.
    assign mem_req  = (state_q == ST_REQ);
    assign mem_we   = mem_req && op_store(op_q);
    assign mem_be   = mem_req ? byte_en(op_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_wd   = store_data(op_q, wdata_q);

    assign stall = op_valid(op) && (state_q != ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign rdata = rdata_q;
    assign exc   = exc_q;
    assign err   = err_q;

`ifdef DM_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (reset && mem_req && mem_ack && mem_we)
            $display("%0t@%h: *%h <= %h %h", $time, pc_q, mem_addr, mem_be, mem_wd);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: a per-cycle expectation schedule is derived from
// access-size arithmetic and compared against the DUT on every falling edge.
module tb_dm_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] addr, wdata, pc;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd;
    logic        mem_ack;
    logic [31:0] mem_rd;
    logic        stall, done, exc, err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dm_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .addr(addr), .wdata(wdata), .PC(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_ack(mem_ack), .mem_rd(mem_rd), .stall(stall),
        .done(done), .rdata(rdata), .exc(exc), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want normal end");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] addr, wdata, rd;
        logic        ack;
        logic        e_req, e_stall, e_done, e_exc, e_err, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd, e_rdata;
        bit          chk_mem, chk_rd;
    } cyc_t;

    cyc_t sched[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Access width in bytes; 0 means "no access".
    function automatic int m_size(input logic [3:0] o);
        case (o)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit m_store(input logic [3:0] o);
        return (o >= 4'd6) && (o <= 4'd8);
    endfunction

    function automatic bit m_signed(input logic [3:0] o);
        return (o == 4'd1) || (o == 4'd2) || (o == 4'd4);
    endfunction

    function automatic bit m_mis(input logic [3:0] o, input logic [31:0] a);
        int s = m_size(o);
        return (s > 0) && ((int'(a[1:0]) % s) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
        int s = m_size(o);
        if (!m_store(o)) return 4'hF;
        return 4'(((1 << s) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wd(input logic [3:0] o, input logic [31:0] w);
        case (m_size(o))
            1:       return {24'd0, w[7:0]} * 32'h0101_0101;
            2:       return {16'd0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] rd);
        int s = m_size(o);
        longint v, lim;
        if (m_store(o) || s == 0) return 32'd0;
        v   = longint'(rd) >> (8 * a[1:0]);
        lim = longint'(1) << (8 * s);
        v   = v % lim;
        if (m_signed(o) && v >= lim / 2) v = v - lim;
        return v[31:0];
    endfunction

    function automatic cyc_t blank(input int id, input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] w);
        cyc_t c;
        c.id = id; c.op = o; c.addr = a; c.wdata = w; c.rd = 32'd0; c.ack = 1'b0;
        c.e_req = 0; c.e_stall = 0; c.e_done = 0; c.e_exc = 0; c.e_err = 0; c.e_we = 0;
        c.e_be = 4'd0; c.e_addr = 32'd0; c.e_wd = 32'd0; c.e_rdata = 32'd0;
        c.chk_mem = 0; c.chk_rd = 0;
        return c;
    endfunction

    // ack_at: REQ cycle (1-based) carrying mem_ack; outside 1..TO means never acknowledged.
    task automatic plan(input int id, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] rd, input int ack_at,
                        input bit idle_after);
        cyc_t c;
        bit   acked = (ack_at >= 1) && (ack_at <= TO);
        int   n_req = acked ? ack_at : TO;
        c = blank(id, o, a, w);
        if (m_size(o) == 0) begin
            sched.push_back(c);
            return;
        end
        c.e_stall = 1;
        sched.push_back(c);
        if (!m_mis(o, a)) begin
            for (int k = 1; k <= n_req; k++) begin
                c = blank(id, o, a, w);
                c.e_stall = 1; c.e_req = 1; c.chk_mem = 1;
                c.e_we = m_store(o); c.e_be = m_be(o, a);
                c.e_addr = a & ~32'd3; c.e_wd = m_wd(o, w);
                c.ack = (k == ack_at);
                c.rd  = (k == ack_at) ? rd : (32'hDEAD_BEEF ^ 32'(k));
                sched.push_back(c);
            end
        end
        c = blank(id, o, a, w);
        c.e_done = 1; c.chk_rd = 1; c.ack = 1'b1; c.rd = 32'hFFFF_FFFF;
        if (m_mis(o, a))  c.e_exc = 1;
        else if (!acked)  c.e_err = 1;
        else              c.e_rdata = m_load(o, a, rd);
        sched.push_back(c);
        if (idle_after) begin
            c = blank(id, 4'd0, 32'd0, 32'd0);
            c.ack = 1'b1;
            sched.push_back(c);
        end
    endtask

    task automatic run_sched();
        cyc_t  c;
        int    n = 0;
        string p;
        while (sched.size() > 0) begin
            c = sched.pop_front();
            @(posedge clk);
            #1;
            op = c.op; addr = c.addr; wdata = c.wdata; pc = 32'h0000_1000 + 32'(c.id * 4);
            mem_ack = c.ack; mem_rd = c.rd;
            @(negedge clk);
            p = $sformatf("t%0d.c%0d", c.id, n);
            check({p, " mem_req"}, mem_req, c.e_req);
            check({p, " stall"},   stall,   c.e_stall);
            check({p, " done"},    done,    c.e_done);
            check({p, " exc"},     exc,     c.e_exc);
            check({p, " err"},     err,     c.e_err);
            if (c.chk_mem) begin
                check({p, " mem_we"},   mem_we,   c.e_we);
                check({p, " mem_be"},   mem_be,   c.e_be);
                check({p, " mem_addr"}, mem_addr, c.e_addr);
                check({p, " mem_wd"},   mem_wd,   c.e_wd);
            end
            if (c.chk_rd) check({p, " rdata"}, rdata, c.e_rdata);
            n++;
        end
    endtask

    initial begin
        reset = 1'b0; op = 4'd0; addr = 32'd0; wdata = 32'd0; pc = 32'd0;
        mem_ack = 1'b0; mem_rd = 32'd0;

        // Hand-computed values that pin the model.
        check("pin sb_be",   m_be(4'd8, 32'h13), 4'b1000);
        check("pin sb_wd",   m_wd(4'd8, 32'hAB), 32'hABAB_ABAB);
        check("pin sw_be",   m_be(4'd6, 32'h10), 4'hF);
        check("pin sh_be",   m_be(4'd7, 32'h02), 4'b1100);
        check("pin lh",      m_load(4'd2, 32'h22, 32'h8001_FFFF), 32'hFFFF_8001);
        check("pin lhu",     m_load(4'd3, 32'h22, 32'h8001_FFFF), 32'h0000_8001);
        check("pin lb",      m_load(4'd4, 32'h23, 32'h7F00_0000), 32'h0000_007F);
        check("pin lw_mis",  32'(m_mis(4'd1, 32'h05)), 32'd1);
        check("pin sb_mis",  32'(m_mis(4'd8, 32'h13)), 32'd0);

        #1;
        check("rst mem_req",  mem_req,  1'b0);
        check("rst mem_we",   mem_we,   1'b0);
        check("rst mem_be",   mem_be,   4'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wd",   mem_wd,   32'd0);
        check("rst done",     done,     1'b0);
        check("rst rdata",    rdata,    32'd0);
        check("rst exc",      exc,      1'b0);
        check("rst err",      err,      1'b0);
        check("rst stall",    stall,    1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        plan(1,  4'd6, 32'h10, 32'h1234_5678, 32'd0,          1, 1);  // SW
        plan(2,  4'd8, 32'h13, 32'h0000_00AB, 32'd0,          2, 1);  // SB
        plan(3,  4'd2, 32'h22, 32'd0,         32'h8001_FFFF,  1, 0);  // LH
        plan(4,  4'd3, 32'h22, 32'd0,         32'h8001_FFFF,  3, 1);  // LHU back-to-back
        plan(5,  4'd4, 32'h23, 32'd0,         32'h7F00_0000,  1, 1);  // LB
        plan(6,  4'd1, 32'h05, 32'd0,         32'd0,          1, 1);  // LW misaligned
        plan(7,  4'd1, 32'h04, 32'd0,         32'd0,          0, 1);  // LW timeout
        plan(8,  4'd5, 32'h21, 32'd0,         32'h1234_F600, TO, 1);  // LBU ack on last cycle
        plan(9,  4'd7, 32'h02, 32'hCAFE_BEEF, 32'd0,          1, 1);  // SH upper half
        plan(10, 4'd3, 32'h21, 32'd0,         32'd0,          1, 0);  // LHU misaligned
        plan(11, 4'd6, 32'h12, 32'h5555_AAAA, 32'd0,          1, 0);  // SW misaligned
        plan(12, 4'd7, 32'h03, 32'h0000_1111, 32'd0,          1, 1);  // SH misaligned
        plan(13, 4'd12, 32'h40, 32'd0,        32'd0,          1, 0);  // reserved op
        plan(14, 4'd4, 32'h01, 32'd0,         32'h0000_8000,  1, 1);  // LB negative
        plan(15, 4'd1, 32'h100, 32'd0,        32'hA5A5_0001,  2, 1);  // LW
        plan(16, 4'd8, 32'h10, 32'h0000_0034, 32'd0,          1, 1);  // SB lane 0
        run_sched();

        // Reset asserted during the second REQ cycle.
        @(posedge clk); #1;
        op = 4'd1; addr = 32'h40; mem_ack = 1'b0;
        @(negedge clk);
        check("arst idle stall",   stall,   1'b1);
        check("arst idle mem_req", mem_req, 1'b0);
        @(posedge clk); #1;
        check("arst req1 mem_req", mem_req, 1'b1);
        @(posedge clk); #1;
        check("arst req2 mem_req", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("arst mem_req",  mem_req,  1'b0);
        check("arst mem_be",   mem_be,   4'd0);
        check("arst mem_addr", mem_addr, 32'd0);
        check("arst done",     done,     1'b0);
        @(negedge clk);
        op = 4'd0; addr = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("arst post%0d done", i),    done,    1'b0);
            check($sformatf("arst post%0d mem_req", i), mem_req, 1'b0);
        end

        plan(20, 4'd6, 32'h20, 32'h0BAD_F00D, 32'd0,          1, 1);  // SW after reset
        plan(21, 4'd1, 32'h24, 32'd0,         32'h0BAD_F00D,  1, 1);  // LW after reset
        run_sched();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
